// File: rtl/seq_det_scheduler.sv
// Bit-serial front end for a one-bit sequence detector: accepts a word, optionally clears
// the detector, shifts the word out MSB-first and reports how often det_y fired in the window.
module seq_det_scheduler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned DET_LAT    = 1,
    parameter int unsigned CLEAR_EACH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_x,
    input  logic             det_y,
    output logic             det_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit
);

    localparam int unsigned LAST_T = WIDTH + DET_LAT - 1;
    localparam int unsigned TW     = $clog2(LAST_T + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [TW-1:0]    t_q, t_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             in_window;
    logic             shift_last;
    logic             drain_last;

    // t counts cycles since the first SHIFT cycle; det_y lags det_x by DET_LAT cycles
    generate
        if (DET_LAT == 0) begin : g_win_mealy
            assign in_window = 1'b1;
        end else begin : g_win_lat
            assign in_window = (t_q >= TW'(DET_LAT));
        end
    endgenerate

    assign shift_last = (t_q == TW'(WIDTH - 1));
    assign drain_last = (t_q == TW'(LAST_T));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (CLEAR_EACH != 0) ? CLEAR : SHIFT;
            CLEAR:   state_d = SHIFT;
            SHIFT:   if (shift_last) state_d = (DET_LAT > 0) ? DRAIN : REPORT;
            DRAIN:   if (drain_last) state_d = REPORT;
            REPORT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q      <= '0;
            t_q         <= '0;
            count_q     <= '0;
            out_count_q <= '0;
        end else begin
            sreg_q      <= sreg_d;
            t_q         <= t_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        sreg_d      = sreg_q;
        t_d         = t_q;
        count_d     = count_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    t_d     = '0;
                    count_d = '0;
                end
            end
            SHIFT, DRAIN: begin
                if (state_q == SHIFT) sreg_d = sreg_q << 1;
                t_d = t_q + TW'(1);
                if (in_window && det_y && (count_q != '1)) count_d = count_q + CNT_W'(1);
            end
            default: ;
        endcase
        // Result register updates only on entry to REPORT so out_count holds between words
        if ((state_q == SHIFT || state_q == DRAIN) && state_d == REPORT) out_count_d = count_d;
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        det_clear = reset || (state_q == CLEAR);
        det_x     = !reset && (state_q == SHIFT) && sreg_q[WIDTH-1];
        out_valid = !reset && (state_q == REPORT);
        out_count = out_count_q;
        out_hit   = |out_count_q;
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: word-level reference model, "101" detector stand-in,
// directed scenarios followed by randomized traffic.
module tb_seq_det_scheduler;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 1;
    localparam int unsigned CLR = 1;
    localparam int unsigned SAT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;
    logic       in_ready, det_x, det_y, det_clear, out_valid, out_hit;
    logic [3:0] out_count;
    logic       in_ready2, det_x2, det_clear2, out_valid2, out_hit2;
    logic [1:0] out_count2;
    logic       det_y2 = 1'b1;
    logic [2:0] hist = '0;
    logic       inject = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    seq_det_scheduler #(.WIDTH(8), .CNT_W(4), .DET_LAT(1), .CLEAR_EACH(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .det_x(det_x), .det_y(det_y), .det_clear(det_clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_hit(out_hit)
    );

    seq_det_scheduler #(.WIDTH(8), .CNT_W(2), .DET_LAT(1), .CLEAR_EACH(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .det_x(det_x2), .det_y(det_y2), .det_clear(det_clear2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_count(out_count2), .out_hit(out_hit2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Overlapping "101" Moore detector, one cycle of latency, reset by det_clear
    always @(posedge clk) hist <= det_clear ? 3'b000 : {hist[1:0], det_x};
    assign det_y = (hist == 3'b101) | inject;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int count101(input logic [7:0] w, input int sat);
        int c = 0;
        for (int i = 0; i + 2 < 8; i++)
            if (w[7-i] && !w[6-i] && w[5-i]) c++;
        return (c > sat) ? sat : c;
    endfunction

    // Reference model: tracks cycles since accept and checks every cycle at negedge
    initial begin : model
        bit         busy = 0;
        int         k = 0;
        logic [7:0] word = '0;
        int         exp_cnt = 0;
        int         last_cnt = 0;
        int         last2 = 0;
        forever begin
            @(negedge clk);
            if (busy && k >= 2 + int'(LAT) && k <= 1 + int'(W + LAT)) inject = 1'b0;
            else inject = 1'($urandom_range(1, 0));
            if (reset) begin
                chk("rst_det_clear", det_clear, 1);
                chk("rst_in_ready", in_ready, 0);
                busy = 0;
                last_cnt = 0;
                last2 = 0;
            end else if (!busy) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_det_x", det_x, 0);
                chk("idle_det_clear", det_clear, 0);
                chk("idle_out_count", out_count, last_cnt);
                chk("idle_out_hit", out_hit, last_cnt != 0);
                chk("idle_out_valid2", out_valid2, 0);
                chk("idle_out_count2", out_count2, last2);
                if (in_valid) begin
                    busy = 1;
                    k = 1;
                    word = in_data;
                    exp_cnt = count101(word, SAT);
                end
            end else begin
                chk("busy_in_ready", in_ready, 0);
                if (k <= int'(CLR + W + LAT)) begin
                    chk("busy_out_valid", out_valid, 0);
                    chk("busy_out_valid2", out_valid2, 0);
                    chk("busy_out_count", out_count, last_cnt);
                    chk("busy_det_clear", det_clear, (CLR != 0 && k == 1));
                    if (k >= 1 + int'(CLR) && k <= int'(CLR + W))
                        chk("shift_det_x", det_x, word[int'(W) - k + int'(CLR)]);
                    else
                        chk("nonshift_det_x", det_x, 0);
                    k++;
                end else begin
                    chk("rep_out_valid", out_valid, 1);
                    chk("rep_out_count", out_count, exp_cnt);
                    chk("rep_out_hit", out_hit, exp_cnt != 0);
                    chk("rep_det_x", det_x, 0);
                    chk("rep_det_clear", det_clear, 0);
                    chk("rep_out_valid2", out_valid2, 1);
                    chk("rep_out_count2", out_count2, 3);
                    chk("rep_out_hit2", out_hit2, 1);
                    if (out_ready) begin
                        busy = 0;
                        last_cnt = exp_cnt;
                        last2 = 3;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, output int acc);
        in_valid = 1'b1;
        in_data = d;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic wait_result(output int rc);
        rc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) chk("result_timeout", 0, 1);
    endtask

    initial begin : stim
        int acc, acc2, rc;
        logic [7:0] xs;

        chk("model_aa", count101(8'hAA, SAT), 3);
        chk("model_b5", count101(8'hB5, SAT), 3);
        chk("model_00", count101(8'h00, SAT), 0);
        chk("model_ff", count101(8'hFF, SAT), 0);

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_det_clear", det_clear, 0);
        tick();

        // 0xAA: serial pattern, latency and count
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        @(negedge clk);
        acc = cyc;
        chk("aa_accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        xs = '0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            xs = {xs[6:0], det_x};
        end
        chk("aa_det_x_seq", xs, 8'b10101010);
        wait_result(rc);
        chk("aa_latency", rc - acc, 11);
        chk("aa_count", out_count, 3);
        chk("aa_hit", out_hit, 1);
        tick();

        // 0xB5 then 0x00 with in_valid held
        in_valid = 1'b1;
        in_data = 8'hB5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        tick();
        in_data = 8'h00;
        wait_result(rc);
        chk("b5_count", out_count, 3);
        acc2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc2 = cyc;
                break;
            end
        end
        chk("b2b_gap", acc2 - rc, 1);
        tick();
        in_valid = 1'b0;
        wait_result(rc);
        chk("zero_count", out_count, 0);
        chk("zero_hit", out_hit, 0);
        tick();

        // 0xFF with back-pressure
        out_ready = 1'b0;
        send_word(8'hFF, acc);
        wait_result(rc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_count", out_count, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 0);
        @(negedge clk);
        chk("bp_after_in_ready", in_ready, 1);
        tick();

        // Reset during SHIFT abandons the word
        send_word(8'hAA, acc);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("abandon_no_valid", out_valid, 0);
        end
        tick();
        send_word(8'hAA, acc);
        wait_result(rc);
        chk("after_rst_count", out_count, 3);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(1, 0));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            reset     = ($urandom_range(79, 0) == 0);
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Bit-serial front-end controller for the single-input/single-output sequence-detector FSM (one-bit `x` in, one-bit `y` out).
- Accepts parallel words over a valid/ready handshake, optionally clears the detector, and shifts each word MSB-first onto the detector input.
- Counts detector assertions inside a latency-aligned sampling window and returns a per-word match count over a second valid/ready handshake.
- Sits between a word-level producer/consumer and one detector instance, sequencing all detector stimulus.

## Interface
- WIDTH, 8: bits per input word; ≥1.
- CNT_W, 4: width of `out_count`; count saturates at 2^CNT_W−1.
- DET_LAT, 1: cycles from driving `det_x` to the corresponding `det_y`; 0 (Mealy) to 3.
- CLEAR_EACH, 1: when 1, one `det_clear` cycle precedes every word; when 0, detector state carries across words.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  word to serialize, MSB first.
- det_x  out  1  serial bit to detector `x`.
- det_y  in  1  detector output `y`.
- det_clear  out  1  synchronous clear to detector (drive its reset).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_count  out  CNT_W  number of cycles `det_y`=1 inside the sampling window.
- out_hit  out  1  `out_count` != 0.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE: `in_ready`=1 (0 while `reset` high). On `in_valid`&&`in_ready`:
  - capture `in_data` into the shift register;
  - clear the count and bit index;
  - go to CLEAR if CLEAR_EACH=1, else SHIFT.
- CLEAR: exactly 1 cycle. `det_clear`=1, `det_x`=0. Then go to SHIFT.
- SHIFT: exactly WIDTH cycles. In the i-th cycle (i=0..WIDTH−1), `det_x`=word[WIDTH−1−i]. Then go to DRAIN if DET_LAT>0, else REPORT.
- DRAIN: exactly DET_LAT cycles, `det_x`=0. Then go to REPORT.
- Sampling window: let t = cycles elapsed since the first SHIFT cycle (t=0 at the first SHIFT cycle).
  - `det_y` is counted when DET_LAT ≤ t ≤ WIDTH−1+DET_LAT, i.e. exactly WIDTH samples.
  - `det_y` outside the window (IDLE, CLEAR, REPORT) is ignored.
- Count rule: increment by 1 per sampled 1; saturate at 2^CNT_W−1, never wrap.
- REPORT:
  - `out_valid`=1; `out_count`/`out_hit` hold stable until `out_ready`=1.
  - On the handshake, go to IDLE. `in_ready` is 1 in the following cycle, not the same cycle; there is no overlap between words.
- `in_data` is ignored outside the accept cycle. `in_valid` may drop at any time without effect.
- Output values outside their active state:
  - `det_x`=0 in IDLE and REPORT;
  - `det_clear`=0 except in CLEAR or while `reset`=1;
  - `out_count`/`out_hit` hold their last value but are valid only with `out_valid`.

## Timing
- Reset (synchronous): at the first rising edge with `reset`=1, state=IDLE, count=0, `out_valid`=0, `out_count`=0, `out_hit`=0, `det_x`=0.
  - `det_clear`=1 combinationally while `reset`=1, so the detector is reset alongside the block.
  - `in_ready`=0 while `reset`=1.
- Latency: with the accept handshake in cycle 0, `out_valid` first rises in cycle 1+CLEAR_EACH+WIDTH+DET_LAT. Defaults give cycle 11.
  - Sample cycles at defaults: 3..10 relative to accept.
- Throughput: one word per 2+CLEAR_EACH+WIDTH+DET_LAT cycles when `out_ready` is held at 1.
- Reset mid-operation (any state): the word is abandoned, no result is produced, and `out_valid`=0 from the next cycle.
- `out_ready`=1 while `out_valid`=0 has no effect.
- In IDLE with `in_valid`=1, the same cycle is the accept cycle; there is no extra bubble.

## Test plan
The bench models the detector as an overlapping "101" Moore detector (DET_LAT=1) reset by `det_clear`. All scenarios use default parameters.
- Reset held 2 cycles, then released → `in_ready`=1, `out_valid`=0, `det_x`=0, `det_clear`=1 during reset only.
- `in_data`=8'hAA, `out_ready`=1 → `det_x` sequence 1,0,1,0,1,0,1,0 in cycles 2..9; `out_valid` in cycle 11; `out_count`=3, `out_hit`=1.
- `in_data`=8'hB5, then 8'h00 back-to-back with `in_valid` held → counts 3 then 0 (`out_hit`=0); second accept occurs exactly 1 cycle after the first result handshake.
- `in_data`=8'hFF with `out_ready`=0 for 5 cycles after `out_valid` → `out_valid` and `out_count`=0 stable all 5 cycles; `in_ready` stays 0 until the cycle after `out_ready`=1.
- Reset pulsed during SHIFT of 8'hAA → no `out_valid`; the next word 8'hAA still reports 3 (detector cleared).
- Force `det_y`=1 constantly with CNT_W=2 → `out_count` saturates at 3; `det_y` pulses during IDLE/CLEAR are not counted.
